// File: rtl/fifo_uart_tx.sv
// Drains one word per frame from a strobe/ack FIFO port and serialises it as
// start bit, LSB-first data, optional parity, and 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TX_EN,
  input  logic             FI_STB,
  input  logic [WIDTH-1:0] FI_DAT,
  output logic             FI_ACK,
  output logic             TXD,
  output logic             TX_BSY,
  output logic [2:0]       dbg_state
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t           state;
  logic [BW-1:0]    baud;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift;
  logic             par_bit;
  logic             baud_done;

  assign baud_done = (baud == BAUD_LAST);
  assign dbg_state = state;

  // Valid/ready: a word transfers on an edge where FI_STB=1 while IDLE with
  // TX_EN=1; FI_ACK pulses for the following clock only, so each frame pops once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      FI_ACK  <= 1'b0;
      TXD     <= 1'b1;
      TX_BSY  <= 1'b0;
    end else begin
      FI_ACK <= 1'b0;
      baud   <= (state == IDLE || baud_done) ? '0 : baud + 1'b1;
      case (state)
        IDLE: begin
          TXD     <= 1'b1;
          TX_BSY  <= 1'b0;
          bit_cnt <= '0;
          if (FI_STB && TX_EN) begin
            shift   <= FI_DAT;
            // Parity is fixed at capture because the shift register is consumed.
            par_bit <= (PARITY == 2) ? ~^FI_DAT : ^FI_DAT;
            FI_ACK  <= 1'b1;
            TXD     <= 1'b0;
            TX_BSY  <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (baud_done) begin
            state   <= DATA;
            TXD     <= shift[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (baud_done) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state <= PAR;
                TXD   <= par_bit;
              end else begin
                state <= STOP;
                TXD   <= 1'b1;
              end
            end else begin
              shift   <= shift >> 1;
              TXD     <= shift[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PAR: begin
          if (baud_done) begin
            state   <= STOP;
            TXD     <= 1'b1;
            bit_cnt <= '0;
          end
        end
        STOP: begin
          TXD <= 1'b1;
          if (baud_done) begin
            if (bit_cnt == STOP_LAST) begin
              state   <= IDLE;
              TX_BSY  <= 1'b0;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          TXD    <= 1'b1;
          TX_BSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three parameter sets share the stimulus; a queue
// stands in for the FIFO and a bit-level frame model gives the expected line.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic [2:0] stb = '0;
  logic [7:0] dat = '0;
  logic [2:0] ack, txd, bsy;
  logic [2:0] st0, st1, st2;

  int checks = 0;
  int failures = 0;
  int cdiv[3]  = '{4, 4, 3};
  int par[3]   = '{0, 1, 2};
  int stopb[3] = '{1, 1, 2};
  int cur = 0;
  logic [7:0] fifo_q[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(.WIDTH(8), .CLK_DIV(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .CLK(clk), .RST(rst), .TX_EN(tx_en), .FI_STB(stb[0]), .FI_DAT(dat),
    .FI_ACK(ack[0]), .TXD(txd[0]), .TX_BSY(bsy[0]), .dbg_state(st0));
  fifo_uart_tx #(.WIDTH(8), .CLK_DIV(4), .PARITY(1), .STOP_BITS(1)) u1 (
    .CLK(clk), .RST(rst), .TX_EN(tx_en), .FI_STB(stb[1]), .FI_DAT(dat),
    .FI_ACK(ack[1]), .TXD(txd[1]), .TX_BSY(bsy[1]), .dbg_state(st1));
  fifo_uart_tx #(.WIDTH(8), .CLK_DIV(3), .PARITY(2), .STOP_BITS(2)) u2 (
    .CLK(clk), .RST(rst), .TX_EN(tx_en), .FI_STB(stb[2]), .FI_DAT(dat),
    .FI_ACK(ack[2]), .TXD(txd[2]), .TX_BSY(bsy[2]), .dbg_state(st2));

  // ---------------- reference model ----------------
  function automatic int frame_len(input int s);
    return cdiv[s] * (1 + 8 + ((par[s] != 0) ? 1 : 0) + stopb[s]);
  endfunction

  function automatic logic expected_line(input int s, input logic [7:0] d, input int t);
    int b;
    b = t / cdiv[s];
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par[s] != 0 && b == 9) return (par[s] == 1) ? ^d : ~^d;
    return 1'b1;
  endfunction

  // ---------------- driver ----------------
  task automatic present();
    stb = '0;
    if (fifo_q.size() > 0) begin
      stb[cur] = 1'b1;
      dat = fifo_q[0];
    end else begin
      dat = 8'($urandom);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input string name, input int drop_at,
                              output logic [63:0] obs);
    int n;
    int bsy_bad;
    int ack_hi;
    int ack_first;
    logic [63:0] exp_v;
    n = frame_len(cur);
    bsy_bad = 0; ack_hi = 0; ack_first = 0;
    obs = '0; exp_v = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      obs[k] = txd[cur];
      exp_v[k] = expected_line(cur, d, k);
      if (bsy[cur] !== 1'b1) bsy_bad++;
      if (ack[cur] === 1'b1) begin
        ack_hi++;
        if (k == 0) ack_first = 1;
      end
      if (k == 0 && ack[cur] === 1'b1 && fifo_q.size() > 0) begin
        fifo_q.delete(0);
        present();
      end
      if (k == drop_at) tx_en = 1'b0;
    end
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s txd_line got=%h exp=%h", name, obs, exp_v);
    end
    checks++;
    if (bsy_bad !== 0) begin
      failures++;
      $display("FAIL %s tx_bsy_low_cycles got=%0d exp=0", name, bsy_bad);
    end
    checks++;
    if (ack_hi !== 1 || ack_first !== 1) begin
      failures++;
      $display("FAIL %s ack_pulse got=%0d first=%0d exp=1 first=1", name, ack_hi, ack_first);
    end
    @(negedge clk);
    checks++;
    if ({txd[cur], bsy[cur], ack[cur]} !== 3'b100) begin
      failures++;
      $display("FAIL %s idle_gap txd/bsy/ack got=%b exp=100", name, {txd[cur], bsy[cur], ack[cur]});
    end
  endtask

  task automatic expect_quiet(input int cycles, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ack[cur] !== 1'b0 || txd[cur] !== 1'b1 || bsy[cur] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL %s quiet_violations got=%0d exp=0", name, bad);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; tx_en = 1'b1; stb = 3'b111; dat = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 3'b111 || bsy !== 3'b000 || ack !== 3'b000) begin
      failures++;
      $display("FAIL reset txd/bsy/ack got=%b/%b/%b exp=111/000/000", txd, bsy, ack);
    end
    checks++;
    if (st0 !== 3'd0 || st1 !== 3'd0 || st2 !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d/%0d/%0d exp=0/0/0", st0, st1, st2);
    end
    stb = '0; tx_en = 1'b0;
    rst = 1'b0;
    cur = 0;
    expect_quiet(4, "post_reset");
  endtask

  task automatic test_basic_a5();
    logic [63:0] obs;
    cur = 0; tx_en = 1'b1;
    fifo_q.push_back(8'hA5);
    present();
    expect_frame(8'hA5, "a5", -1, obs);
    checks++;
    if (fifo_q.size() != 0 || stb !== 3'b000) begin
      failures++;
      $display("FAIL a5_popped q=%0d stb=%b exp=0/000", fifo_q.size(), stb);
    end
  endtask

  task automatic test_parity();
    logic [63:0] obs;
    cur = 1;
    fifo_q.push_back(8'h07);
    present();
    expect_frame(8'h07, "even_07", -1, obs);
    checks++;
    if (obs[36] !== 1'b1) begin
      failures++;
      $display("FAIL even_parity_bit got=%b exp=1", obs[36]);
    end
    cur = 2;
    fifo_q.push_back(8'h07);
    present();
    expect_frame(8'h07, "odd_07", -1, obs);
    checks++;
    if (obs[27] !== 1'b0) begin
      failures++;
      $display("FAIL odd_parity_bit got=%b exp=0", obs[27]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] obs;
    logic [7:0] words[3];
    words = '{8'h01, 8'h80, 8'hFF};
    cur = 0;
    foreach (words[i]) fifo_q.push_back(words[i]);
    present();
    foreach (words[i]) expect_frame(words[i], "fifo", -1, obs);
    checks++;
    if (fifo_q.size() != 0 || stb[0] !== 1'b0) begin
      failures++;
      $display("FAIL fifo_drained q=%0d stb=%b exp=0/0", fifo_q.size(), stb[0]);
    end
    expect_quiet(8, "fifo_tail");
  endtask

  task automatic test_random();
    logic [63:0] obs;
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      cur = $urandom_range(0, 2);
      present();
      expect_quiet($urandom_range(1, 5), "rand_gap");
      d = 8'($urandom);
      fifo_q.push_back(d);
      present();
      expect_frame(d, "rand", -1, obs);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] obs;
    logic [7:0] d;
    cur = 0;
    fifo_q.push_back(8'h55);
    present();
    @(negedge clk);
    checks++;
    if (ack[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_start ack got=%b exp=1", ack[0]);
    end
    if (ack[0] === 1'b1) fifo_q.delete(0);
    present();
    repeat (12) @(negedge clk);
    checks++;
    if (bsy[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_busy got=%b exp=1", bsy[0]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (txd[0] !== 1'b1 || bsy[0] !== 1'b0 || ack[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async txd/bsy/ack got=%b%b%b exp=100", txd[0], bsy[0], ack[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    expect_quiet(5, "rst_mid_after");
    d = 8'($urandom);
    fifo_q.push_back(d);
    present();
    expect_frame(d, "rst_mid_clean", -1, obs);
  endtask

  task automatic test_tx_en();
    logic [63:0] obs;
    logic [7:0] d;
    cur = 0;
    tx_en = 1'b0;
    d = 8'($urandom);
    fifo_q.push_back(d);
    present();
    expect_quiet(100, "tx_en_low");
    checks++;
    if (fifo_q.size() != 1) begin
      failures++;
      $display("FAIL tx_en_low_no_pop q=%0d exp=1", fifo_q.size());
    end
    tx_en = 1'b1;
    expect_frame(d, "tx_en_rise", -1, obs);
  endtask

  task automatic test_en_drop();
    logic [63:0] obs;
    logic [7:0] d0, d1;
    cur = 2;
    tx_en = 1'b1;
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    fifo_q.push_back(d0);
    fifo_q.push_back(d1);
    present();
    expect_frame(d0, "en_drop", 15, obs);
    checks++;
    if (obs[35:30] !== 6'b111111) begin
      failures++;
      $display("FAIL en_drop_stop_bits got=%b exp=111111", obs[35:30]);
    end
    expect_quiet(30, "en_drop_hold");
    checks++;
    if (fifo_q.size() != 1) begin
      failures++;
      $display("FAIL en_drop_no_pop q=%0d exp=1", fifo_q.size());
    end
    tx_en = 1'b1;
    expect_frame(d1, "en_drop_resume", -1, obs);
  endtask

  initial begin
    test_reset();
    test_basic_a5();
    test_parity();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_tx_en();
    test_en_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
